// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions for the iterative RV32M multiply/divide unit.
// Contents:
//   muldiv_op_e    - RV32M funct3 encodings
//   muldiv_state_e - multiply/divide FSM states
//   MULDIV_ITERS   - iterations per non-special operation
//   DIV0_QUOT      - quotient returned for divide by zero
//   INT_MIN        - most negative 32-bit value (signed overflow operand/result)
package cpu_pkg;

    typedef enum logic [2:0] {
        OpMul    = 3'b000,
        OpMulh   = 3'b001,
        OpMulhsu = 3'b010,
        OpMulhu  = 3'b011,
        OpDiv    = 3'b100,
        OpDivu   = 3'b101,
        OpRem    = 3'b110,
        OpRemu   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFin
    } muldiv_state_e;

    localparam int unsigned MULDIV_ITERS = 32;
    localparam logic [31:0] DIV0_QUOT    = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN      = 32'h8000_0000;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit in the execute stage.
// Multiplies by shift-add and divides by restoring division, one bit per cycle over
// 32 cycles on operand magnitudes; signs are reapplied when the result is registered.
// Divide-by-zero and signed overflow bypass the iterations with a preset result.
// Ports:
//   clock   - system clock, rising edge
//   reset   - synchronous active-high reset
//   start   - request an operation (accepted only in idle)
//   flush   - abort in-flight operation, no done
//   funct3  - RV32M operation select
//   rs1_val - operand A (multiplicand / dividend)
//   rs2_val - operand B (multiplier / divisor)
//   busy    - unit not idle (decoded from state)
//   stall   - freeze front of pipeline (combinational)
//   done    - one-cycle pulse, result valid
//   result  - registered result, held until the next accepted start
module ex_muldiv
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    muldiv_state_e state_q, state_d;
    muldiv_op_e    op_q, op_d, op_in;
    logic          a_neg_q, a_neg_d;
    logic          b_neg_q, b_neg_d;
    logic [5:0]    cnt_q, cnt_d;
    // Multiply: {partial product high, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting out / quotient shifting in}.
    logic [2*XLEN-1:0] acc_q, acc_d;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              done_q, done_d;

    logic            accept, last_iter;
    logic            a_signed_in, b_signed_in, a_neg_in, b_neg_in;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, special_in;
    logic [XLEN-1:0] preset;

    logic [XLEN:0]     mul_sum, div_trial, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, iter_next, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fin_result;

    assign accept    = (state_q == StIdle) && start && !flush;
    assign last_iter = (cnt_q == 6'(MULDIV_ITERS - 1));

    // Operand conditioning: signedness per op, magnitudes, special-case divides.
    always_comb begin
        op_in       = muldiv_op_e'(funct3);
        a_signed_in = 1'b0;
        b_signed_in = 1'b0;
        unique case (op_in)
            OpMulh:        begin a_signed_in = 1'b1; b_signed_in = 1'b1; end
            OpMulhsu:      a_signed_in = 1'b1;
            OpDiv, OpRem:  begin a_signed_in = 1'b1; b_signed_in = 1'b1; end
            default:       ;
        endcase
        a_neg_in   = a_signed_in & rs1_val[XLEN-1];
        b_neg_in   = b_signed_in & rs2_val[XLEN-1];
        a_mag      = a_neg_in ? -rs1_val : rs1_val;
        b_mag      = b_neg_in ? -rs2_val : rs2_val;
        div_zero   = funct3[2] && (rs2_val == '0);
        div_ovf    = funct3[2] && !funct3[0] && (rs1_val == INT_MIN) && (rs2_val == '1);
        special_in = div_zero || div_ovf;
        // funct3[1] distinguishes REM* from DIV*.
        if (div_zero) begin
            preset = funct3[1] ? rs1_val : DIV0_QUOT;
        end else begin
            preset = funct3[1] ? '0 : INT_MIN;
        end
    end

    // One iteration step for each algorithm.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_trial - {1'b0, opb_q};
        // Negative trial difference means restore the shifted remainder, quotient bit 0.
        if (div_diff[XLEN]) begin
            div_next = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
        iter_next = op_q[2] ? div_next : mul_next;
    end

    // Sign correction and result select, applied to the final iteration's value.
    always_comb begin
        prod_fix = (a_neg_q ^ b_neg_q) ? -iter_next : iter_next;
        quo_fix  = (a_neg_q ^ b_neg_q) ? -iter_next[XLEN-1:0] : iter_next[XLEN-1:0];
        rem_fix  = a_neg_q ? -iter_next[2*XLEN-1:XLEN] : iter_next[2*XLEN-1:XLEN];
        fin_result = '0;
        unique case (op_q)
            OpMul:                     fin_result = prod_fix[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu: fin_result = prod_fix[2*XLEN-1:XLEN];
            OpDiv, OpDivu:             fin_result = quo_fix;
            OpRem, OpRemu:             fin_result = rem_fix;
            default:                   ;
        endcase
    end

    // Datapath next state. Results are registered on entry to FIN so done/result
    // are valid during the FIN cycle itself.
    always_comb begin
        op_d     = op_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        result_d = result_q;
        done_d   = 1'b0;
        if (accept) begin
            op_d    = op_in;
            a_neg_d = a_neg_in;
            b_neg_d = b_neg_in;
            cnt_d   = '0;
            if (funct3[2]) begin
                acc_d = {{XLEN{1'b0}}, a_mag};
                opb_d = b_mag;
            end else begin
                acc_d = {{XLEN{1'b0}}, b_mag};
                opb_d = a_mag;
            end
            if (special_in) begin
                result_d = preset;
                done_d   = 1'b1;
            end
        end else if ((state_q == StCalc) && !flush) begin
            acc_d = iter_next;
            cnt_d = cnt_q + 6'd1;
            if (last_iter) begin
                result_d = fin_result;
                done_d   = 1'b1;
            end
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = special_in ? StFin : StCalc;
                end
            end
            StCalc: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (last_iter) begin
                    state_d = StFin;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy  = (state_q != StIdle);
        stall = accept || (state_q == StCalc);
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q     <= OpMul;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            op_q     <= op_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule
